// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcodes, CCR bit positions, multiplier states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_NOT   = 4'd1,
      OP_INC   = 4'd2,
      OP_DEC   = 4'd3,
      OP_PASSD = 4'd4,
      OP_ADD   = 4'd5,
      OP_SUB   = 4'd6,
      OP_AND   = 4'd7,
      OP_OR    = 4'd8,
      OP_SHL   = 4'd9,
      OP_SHR   = 4'd10,
      OP_SETC  = 4'd11,
      OP_CLRC  = 4'd12,
      OP_PASSS = 4'd13,
      OP_RSTF  = 4'd14,
      OP_MUL   = 4'd15
   } op_e;

   localparam int CCR_Z = 0;
   localparam int CCR_N = 1;
   localparam int CCR_C = 2;

   typedef logic [2:0] flags_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode-to-execute op bus plus the registered result/flag return path.
interface alu_exec_stage_if
   import alu_pkg::*;
#(
   parameter int N   = 16,
   parameter int SHW = $clog2(N)
) ();

   logic           in_valid;
   logic           in_ready;
   logic [3:0]     op;
   logic [N-1:0]   src;
   logic [N-1:0]   dst;
   logic [SHW-1:0] shamt;
   flags_t         flags_in;
   logic           flush;
   logic           out_valid;
   logic [N-1:0]   result;
   flags_t         ccr;

   modport master (
      output in_valid, op, src, dst, shamt, flags_in, flush,
      input  in_ready, out_valid, result, ccr
   );

   modport slave (
      input  in_valid, op, src, dst, shamt, flags_in, flush,
      output in_ready, out_valid, result, ccr
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per BUSY cycle.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   mul_state_e     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [2*N-1:0] prod_q, prod_d;
   logic [N:0]     step_sum;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      // Multiplier sits in the low half and shifts out as the sum grows in the high half.
      step_sum = {1'b0, prod_q[2*N-1:N]} + {1'b0, {N{prod_q[0]}} & mcand_q};
      case (state_q)
         MUL_BUSY: begin
            prod_d = {step_sum, prod_q[N-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = MUL_DONE;
         end
         default: begin
            state_d = MUL_IDLE;
            if (start) begin
               state_d = MUL_BUSY;
               cnt_d   = CW'(N - 1);
               mcand_d = a;
               prod_d  = {{N{1'b0}}, b};
            end
         end
      endcase
      if (abort) state_d = MUL_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= MUL_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end

   assign busy    = (state_q == MUL_BUSY);
   assign done    = busy && (cnt_q == '0);
   // Final step's value, so the stage can register the product on the edge entering DONE.
   assign product = prod_d;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU with internal CCR {C,N,Z}, flush and valid/ready.
// Define ALU_MUL_EN to add the iterative multiplier on op 15; otherwise op 15 is a NOP.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int N   = 16,
   parameter int SHW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_exec_stage_if.slave bus
);

   localparam logic [N:0]   ONE_W = (N+1)'(1);
   localparam logic [N-1:0] ONE_N = N'(1);

   logic [N-1:0]   result_q, result_d;
   flags_t         ccr_q, ccr_d;
   logic           out_valid_q, out_valid_d;
   logic           accept, set_zn;
   logic [N:0]     wide;
   logic [SHW-1:0] shamt;
   op_e            op;

   assign op     = op_e'(bus.op);
   assign shamt  = bus.shamt;
   assign accept = bus.in_valid & bus.in_ready;

`ifdef ALU_MUL_EN
   logic           mul_start, mul_busy, mul_done;
   logic [2*N-1:0] mul_prod;

   assign mul_start = accept & ~bus.flush & (op == OP_MUL);

   alu_mul_iter #(.N(N)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .abort   (bus.flush),
      .a       (bus.src),
      .b       (bus.dst),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   assign bus.in_ready = ~mul_busy;
`else
   assign bus.in_ready = 1'b1;
`endif

   always_comb begin
      result_d    = result_q;
      ccr_d       = ccr_q;
      out_valid_d = 1'b0;
      set_zn      = 1'b0;
      wide        = '0;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end
`ifdef ALU_MUL_EN
      else if (mul_done) begin
         result_d     = mul_prod[N-1:0];
         ccr_d[CCR_C] = |mul_prod[2*N-1:N];
         set_zn       = 1'b1;
         out_valid_d  = 1'b1;
      end
`endif
      else if (accept) begin
         out_valid_d = 1'b1;
         case (op)
            OP_NOT:   begin result_d = ~bus.src; set_zn = 1'b1; end
            OP_INC:   begin {ccr_d[CCR_C], result_d} = {1'b0, bus.src} + ONE_W; set_zn = 1'b1; end
            OP_DEC:   begin
               result_d     = bus.src - ONE_N;
               ccr_d[CCR_C] = (bus.src == '0);
               set_zn       = 1'b1;
            end
            OP_PASSD: result_d = bus.dst;
            OP_ADD:   begin {ccr_d[CCR_C], result_d} = {1'b0, bus.src} + {1'b0, bus.dst}; set_zn = 1'b1; end
            // Bit N of the widened difference is the unsigned borrow.
            OP_SUB:   begin {ccr_d[CCR_C], result_d} = {1'b0, bus.src} - {1'b0, bus.dst}; set_zn = 1'b1; end
            OP_AND:   begin result_d = bus.src & bus.dst; set_zn = 1'b1; end
            OP_OR:    begin result_d = bus.src | bus.dst; set_zn = 1'b1; end
            OP_SHL:   begin
               wide     = {1'b0, bus.src} << shamt;
               result_d = wide[N-1:0];
               if (shamt != '0) ccr_d[CCR_C] = wide[N];
               set_zn   = 1'b1;
            end
            OP_SHR:   begin
               wide     = {bus.src, 1'b0} >> shamt;
               result_d = wide[N:1];
               if (shamt != '0) ccr_d[CCR_C] = wide[0];
               set_zn   = 1'b1;
            end
            OP_SETC:  ccr_d[CCR_C] = 1'b1;
            OP_CLRC:  ccr_d[CCR_C] = 1'b0;
            OP_PASSS: result_d = bus.src;
            OP_RSTF:  ccr_d = bus.flags_in;
`ifdef ALU_MUL_EN
            OP_MUL:   out_valid_d = 1'b0;
`endif
            default:  ;
         endcase
      end
      if (set_zn) begin
         ccr_d[CCR_Z] = (result_d == '0);
         ccr_d[CCR_N] = result_d[N-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q    <= '0;
         ccr_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         ccr_q       <= ccr_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.ccr       = ccr_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered, parametrised execute-stage ALU for the pipelined processor. It replaces the purely combinational ALU.
- Holds the architectural condition-code register (CCR: Z, N, C) internally, so flags persist across non-ALU ops without combinational feedback.
- Adds shift-by-immediate, flag restore (RTI), flush, and a valid/ready handshake. Optionally adds an iterative multiplier.

Parameters:
- N, 16, datapath width (>= 4).
- SHW, $clog2(N), shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  decode stage presents an op.
- in_ready  out  1  stage can accept an op this cycle.
- op  in  4  opcode (see Behaviour).
- src  in  N  source operand.
- dst  in  N  destination operand.
- shamt  in  SHW  shift amount for SHL/SHR.
- flags_in  in  3  {C,N,Z} restored by op RSTF.
- flush  in  1  kill in-flight and accepted op.
- out_valid  out  1  result registered and valid.
- result  out  N  registered result.
- ccr  out  3  {C,N,Z} architectural flags, registered.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, result=0, ccr=3'b000, multiplier idle, in_ready=1. Reset mid-multiply aborts it.
- Accept when in_valid & in_ready. Result, out_valid and ccr update at the next posedge (latency 1). With no accept, out_valid=0 the next cycle and result holds.
- Opcodes and flag effects ("ZN" = Z/N from result):
  - 0 NOP: result holds; ccr unchanged; out_valid=1 (bubble carried).
  - 1 NOT: result = ~src; ZN; C unchanged.
  - 2 INC: result = src+1; C = carry out; ZN.
  - 3 DEC: result = src-1; C = borrow (src==0); ZN.
  - 4 PASSD: result = dst; ccr unchanged.
  - 5 ADD: result = src+dst; C = bit N of the N+1-bit sum; ZN.
  - 6 SUB: result = src-dst; C = 1 iff src<dst (unsigned); ZN.
  - 7 AND, 8 OR: bitwise; ZN; C unchanged.
  - 9 SHL: result = src<<shamt; C = src[N-shamt]. shamt=0 gives result=src with C unchanged. ZN.
  - 10 SHR: logical; C = src[shamt-1]. shamt=0 as for SHL. ZN.
  - 11 SETC: C=1. 12 CLRC: C=0. Result holds in both.
  - 13 PASSS: result = src; ccr unchanged (load/store address path).
  - 14 RSTF: ccr = flags_in; result holds.
  - 15 MUL: see Optional Feature.
- Z is defined as result==0 (full N bits). N is result[N-1].
- flush=1 at a posedge: out_valid=0, any input offered that cycle is dropped, multiplier aborts to idle, ccr and result unchanged. flush has priority over accept but not over reset.
- in_ready=1 except while the multiplier is busy.

Optional Feature:
- Macro ALU_MUL_EN.
- When defined, op 15 MUL is an iterative shift-add multiplier.
  - Accept loads operands; in_ready drops to 0 for N cycles (states IDLE -> BUSY with counter N-1..0 -> DONE).
  - On the DONE posedge, result = low N bits of src*dst (unsigned), C = |high N bits|, ZN from the low half, out_valid=1 for one cycle. in_ready returns to 1 in the same cycle.
  - Total latency is N+1 cycles from accept.
- When not defined, op 15 behaves exactly as NOP, in_ready is tied to 1, and no multiplier state exists.

Decomposition:
- Package alu_pkg:
  - opcode enum (OP_NOP..OP_MUL with the values above);
  - CCR bit indices (CCR_Z=0, CCR_N=1, CCR_C=2);
  - typedef for the flag triple.
- One sub-module, alu_mul_iter (N-parameterised, start/busy/done). It is instantiated only under ALU_MUL_EN.
- The combinational op decode stays inside alu_exec_stage.

Test Plan:
- Reset then ADD src=16'hFFFF, dst=16'h0001 -> next cycle result=0, ccr={C=1,N=0,Z=1}, out_valid=1.
- SUB src=3, dst=5 -> result=16'hFFFE, C=1, N=1, Z=0. Then PASSD dst=16'h1234 -> result=16'h1234 with ccr unchanged.
- SHL src=16'h8001, shamt=1 -> result=16'h0002, C=1. SHR src=16'h0001, shamt=0 -> result=16'h0001, C unchanged.
- SETC, then RSTF flags_in=3'b010 -> ccr=3'b010. CLRC -> C=0 with N=1 kept.
- flush asserted in the same cycle as an ADD accept -> out_valid=0 next cycle, ccr and result unchanged. rst_n=0 mid-stream -> all outputs at reset values the next cycle.
- ALU_MUL_EN defined: MUL src=16'h0100, dst=16'h0100 -> in_ready=0 for 16 cycles, then result=0, C=1, Z=1. A second op held on in_valid is accepted only after DONE.
